// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem request handshake, redirect
// tracking and the IF/ID pipeline register with stall/flush support.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stallD,
  input  logic          flushD,
  input  logic          PCSrcE,
  input  logic [15:0]   PCTargetE,
  fetch_stage_if.master imem,
  output logic [15:0]   inst,
  output logic [15:0]   PCD,
  output logic [15:0]   PCPlus2,
  output logic          validD
);

  localparam int unsigned XLEN = 16;
  localparam logic [XLEN-1:0] PC_INIT = {RESET_PC[XLEN-1:1], 1'b0};

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pcf, pcf_n;
  logic            req_q;
  logic            pend, pend_n;
  logic [XLEN-1:0] tgt, tgt_n;
  logic [XLEN-1:0] hold_inst, hold_inst_n;
  logic [XLEN-1:0] hold_pc, hold_pc_n;

  logic            ifid_we;
  logic [XLEN-1:0] ifid_inst;
  logic [XLEN-1:0] ifid_pc;

  logic [XLEN-1:0] tgt_in;
  logic [XLEN-1:0] pcf_plus2;

  assign tgt_in    = {PCTargetE[XLEN-1:1], 1'b0};
  assign pcf_plus2 = pcf + XLEN'(2);

  // imem address comes straight from PCF so it cannot move mid-request
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pcf;

  // State register and all datapath flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BOOT;
      pcf       <= PC_INIT;
      req_q     <= 1'b0;
      pend      <= 1'b0;
      tgt       <= '0;
      hold_inst <= NOP_INST;
      hold_pc   <= '0;
      inst      <= NOP_INST;
      PCD       <= '0;
      PCPlus2   <= '0;
      validD    <= 1'b0;
    end else begin
      state     <= state_n;
      pcf       <= pcf_n;
      req_q     <= (state_n == FETCH);
      pend      <= pend_n;
      tgt       <= tgt_n;
      hold_inst <= hold_inst_n;
      hold_pc   <= hold_pc_n;
      if (flushD) begin
        inst    <= NOP_INST;
        PCD     <= '0;
        PCPlus2 <= '0;
        validD  <= 1'b0;
      end else if (ifid_we) begin
        inst    <= ifid_inst;
        PCD     <= ifid_pc;
        PCPlus2 <= ifid_pc + XLEN'(2);
        validD  <= 1'b1;
      end
    end
  end

  // Next-state, PC selection and IF/ID write selection
  always_comb begin
    state_n     = state;
    pcf_n       = pcf;
    pend_n      = pend;
    tgt_n       = tgt;
    hold_inst_n = hold_inst;
    hold_pc_n   = hold_pc;
    ifid_we     = 1'b0;
    ifid_inst   = hold_inst;
    ifid_pc     = hold_pc;

    case (state)
      BOOT: begin
        state_n = FETCH;
      end

      FETCH: begin
        if (imem.imem_ready) begin
          if (PCSrcE) begin
            // a redirect arriving with completion is the youngest target
            pcf_n  = tgt_in;
            pend_n = 1'b0;
          end else if (pend) begin
            pcf_n  = tgt;
            pend_n = 1'b0;
          end else if (stallD || flushD) begin
            hold_inst_n = imem.imem_rdata;
            hold_pc_n   = pcf;
            pcf_n       = pcf_plus2;
            state_n     = HOLD;
          end else begin
            ifid_we   = 1'b1;
            ifid_inst = imem.imem_rdata;
            ifid_pc   = pcf;
            pcf_n     = pcf_plus2;
          end
        end else if (PCSrcE) begin
          pend_n = 1'b1;
          tgt_n  = tgt_in;
        end
      end

      HOLD: begin
        if (PCSrcE) begin
          pcf_n       = tgt_in;
          hold_inst_n = NOP_INST;
          hold_pc_n   = '0;
          state_n     = FETCH;
        end else if (!stallD && !flushD) begin
          ifid_we = 1'b1;
          state_n = FETCH;
        end
      end

      default: begin
        state_n = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, waits, stall/hold, redirects, wrap, flush, reset.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stallD;
  logic        flushD;
  logic        PCSrcE;
  logic [15:0] PCTargetE;
  logic [15:0] inst;
  logic [15:0] PCD;
  logic [15:0] PCPlus2;
  logic        validD;

  int total = 0;
  int bad   = 0;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC (16'h0000),
    .NOP_INST (16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stallD    (stallD),
    .flushD    (flushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (bus),
    .inst      (inst),
    .PCD       (PCD),
    .PCPlus2   (PCPlus2),
    .validD    (validD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] ei, input logic [15:0] ep,
                            input logic [15:0] epp, input logic ev);
    check({tag, ".inst"}, inst, ei);
    check({tag, ".pcd"}, PCD, ep);
    check({tag, ".pcplus2"}, PCPlus2, epp);
    check({tag, ".valid"}, 16'(validD), 16'(ev));
  endtask

  task automatic check_bus(input string tag, input logic ereq, input logic [15:0] eaddr);
    check({tag, ".req"}, 16'(bus.imem_req), 16'(ereq));
    check({tag, ".addr"}, bus.imem_addr, eaddr);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; stallD = 1'b0; flushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 16'h0000;
    bus.imem_ready = 1'b0; bus.imem_rdata = 16'h0000;
    #1;
    check_bus("reset", 1'b0, 16'h0000);
    check_ifid("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0);

    // boot: one cycle with no request
    repeat (2) cyc();
    rst = 1'b1;
    #1 check_bus("boot", 1'b0, 16'h0000);
    cyc();
    check_bus("fetch0", 1'b1, 16'h0000);
    bus.imem_ready = 1'b1; bus.imem_rdata = 16'h1234;
    cyc();
    check_ifid("i0", 16'h1234, 16'h0000, 16'h0002, 1'b1);
    check_bus("fetch2", 1'b1, 16'h0002);
    bus.imem_rdata = 16'h5678;
    cyc();
    check_ifid("i1", 16'h5678, 16'h0002, 16'h0004, 1'b1);
    check_bus("fetch4", 1'b1, 16'h0004);

    // three wait cycles at 0004
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_bus("wait4", 1'b1, 16'h0004);
      check_ifid("wait4", 16'h5678, 16'h0002, 16'h0004, 1'b1);
    end
    bus.imem_ready = 1'b1; bus.imem_rdata = 16'h9ABC;
    cyc();
    check_ifid("i2", 16'h9ABC, 16'h0004, 16'h0006, 1'b1);
    check_bus("fetch6", 1'b1, 16'h0006);

    // stall while fetch of 0006 completes
    stallD = 1'b1; bus.imem_rdata = 16'hDEF0;
    cyc();
    check_bus("hold1", 1'b0, 16'h0008);
    check_ifid("hold1", 16'h9ABC, 16'h0004, 16'h0006, 1'b1);
    bus.imem_ready = 1'b0;
    cyc();
    check_bus("hold2", 1'b0, 16'h0008);
    check_ifid("hold2", 16'h9ABC, 16'h0004, 16'h0006, 1'b1);
    stallD = 1'b0;
    cyc();
    check_ifid("unhold", 16'hDEF0, 16'h0006, 16'h0008, 1'b1);
    check_bus("fetch8", 1'b1, 16'h0008);

    // redirect to 0041 while 0008 waits, flush in between
    PCSrcE = 1'b1; PCTargetE = 16'h0041;
    cyc();
    check_bus("redir_wait1", 1'b1, 16'h0008);
    PCSrcE = 1'b0; flushD = 1'b1;
    cyc();
    check_bus("redir_wait2", 1'b1, 16'h0008);
    check_ifid("flush", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    flushD = 1'b0; bus.imem_ready = 1'b1; bus.imem_rdata = 16'hBAD0;
    cyc();
    check_bus("redir_tgt", 1'b1, 16'h0040);
    check_ifid("discard", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    bus.imem_rdata = 16'h1111;
    cyc();
    check_ifid("i40", 16'h1111, 16'h0040, 16'h0042, 1'b1);
    check_bus("fetch42", 1'b1, 16'h0042);

    // second redirect before completion overwrites the first
    bus.imem_ready = 1'b0; PCSrcE = 1'b1; PCTargetE = 16'h0100;
    cyc();
    PCTargetE = 16'h0203;
    cyc();
    check_bus("redir_ovr_wait", 1'b1, 16'h0042);
    PCSrcE = 1'b0; bus.imem_ready = 1'b1; bus.imem_rdata = 16'h2222;
    cyc();
    check_bus("redir_ovr", 1'b1, 16'h0202);
    check_ifid("redir_ovr", 16'h1111, 16'h0040, 16'h0042, 1'b1);

    // redirect with completion to FFFE, then wrap
    PCSrcE = 1'b1; PCTargetE = 16'hFFFE; bus.imem_rdata = 16'h3333;
    cyc();
    check_bus("fetchFFFE", 1'b1, 16'hFFFE);
    check_ifid("redir_done", 16'h1111, 16'h0040, 16'h0042, 1'b1);
    PCSrcE = 1'b0; bus.imem_rdata = 16'h4444;
    cyc();
    check_ifid("wrap", 16'h4444, 16'hFFFE, 16'h0000, 1'b1);
    check_bus("wrap", 1'b1, 16'h0000);

    // flush coinciding with completion keeps the instruction in the hold buffer
    flushD = 1'b1; bus.imem_rdata = 16'h5555;
    cyc();
    check_ifid("flush_cmp", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    check_bus("flush_cmp", 1'b0, 16'h0002);
    flushD = 1'b0; bus.imem_ready = 1'b0;
    cyc();
    check_ifid("flush_rel", 16'h5555, 16'h0000, 16'h0002, 1'b1);
    check_bus("flush_rel", 1'b1, 16'h0002);

    // asynchronous reset in the middle of a wait
    cyc();
    check_bus("prereset", 1'b1, 16'h0002);
    #2 rst = 1'b0;
    #1;
    check_bus("async_rst", 1'b0, 16'h0000);
    check_ifid("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    bus.imem_ready = 1'b1; bus.imem_rdata = 16'h7777;
    cyc();
    check_ifid("rst_ready", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b1;
    #1 check_bus("reboot", 1'b0, 16'h0000);
    cyc();
    check_bus("refetch", 1'b1, 16'h0000);
    cyc();
    check_ifid("refetch", 16'h7777, 16'h0000, 16'h0002, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
